// File: rtl/booth_seq_mul16.sv
`timescale 1ns/1ps
// Sequential radix-4 Modified Booth multiplier, 16x16 -> 32, signed or unsigned.
// Retires one Booth digit per clock with valid/ready handshakes on operands and product.
module booth_seq_mul16 #(
    parameter int EARLY_TERM = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sgn,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] p,
    output logic        busy,
    output logic [3:0]  ndig
);

    localparam bit ET = (EARLY_TERM != 0);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [33:0] mcand_q, mcand_d;
    logic [18:0] mplier_q, mplier_d;
    logic [33:0] acc_q, acc_d;
    logic [3:0]  ndig_q, ndig_d;
    logic [31:0] p_q, p_d;
    logic        sgn_q, sgn_d;
    logic [33:0] pp;
    logic [33:0] sum;
    logic        last_digit;
    logic        rest_zero;

    // mplier_q holds {ext b, b[-1]} shifted right 2 per digit, so bits [2:0] are always the
    // current triplet and the whole register holds exactly the not-yet-consumed bits.
    assign last_digit = (ndig_q == (sgn_q ? 4'd7 : 4'd8));
    assign rest_zero  = ET && ((mplier_q == '0) || (&mplier_q));

    always_comb begin
        pp = '0;
        case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = ~(mcand_q << 1) + 34'd1;
            3'b101, 3'b110: pp = ~mcand_q + 34'd1;
            default:        pp = '0;
        endcase
    end

    assign sum = acc_q + pp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_RUN;
            S_RUN:   if (rest_zero || last_digit) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        p         = p_q;
        ndig      = ndig_q;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        ndig_d   = ndig_q;
        p_d      = p_q;
        sgn_d    = sgn_q;
        if (state_q == S_IDLE && in_valid) begin
            mcand_d  = sgn ? {{18{a[15]}}, a} : {18'd0, a};
            mplier_d = {(sgn ? {2{b[15]}} : 2'b00), b, 1'b0};
            acc_d    = '0;
            ndig_d   = '0;
            sgn_d    = sgn;
        end else if (state_q == S_RUN) begin
            if (rest_zero) begin
                p_d = acc_q[31:0];
            end else begin
                acc_d    = sum;
                mcand_d  = mcand_q << 2;
                mplier_d = {{2{mplier_q[18]}}, mplier_q[18:2]};
                ndig_d   = ndig_q + 4'd1;
                if (last_digit) p_d = sum[31:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            ndig_q   <= '0;
            p_q      <= '0;
            sgn_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            ndig_q   <= ndig_d;
            p_q      <= p_d;
            sgn_q    <= sgn_d;
        end
    end

endmodule

// File: tb/tb_booth_seq_mul16.sv
`timescale 1ns/1ps
// Bench for booth_seq_mul16: u0 runs with EARLY_TERM = 0, u1 with EARLY_TERM = 1, fed the
// same operands; outputs are sampled on the falling clock edge.
module tb_booth_seq_mul16;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, sgn, out_ready;
    logic [15:0] a, b;
    logic        in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [31:0] p0, p1;
    logic [3:0]  ndig0, ndig1;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [31:0] res_p0, res_p1;
    logic [3:0]  res_n0, res_n1;
    int          res_l0, res_l1;

    always #5 clk = ~clk;

    booth_seq_mul16 #(.EARLY_TERM(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .sgn(sgn), .out_valid(out_valid0), .out_ready(out_ready),
        .p(p0), .busy(busy0), .ndig(ndig0)
    );

    booth_seq_mul16 #(.EARLY_TERM(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .sgn(sgn), .out_valid(out_valid1), .out_ready(out_ready),
        .p(p1), .busy(busy1), .ndig(ndig1)
    );

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [31:0] xe, ye;
        xe = s ? {{16{x[15]}}, x} : {16'd0, x};
        ye = s ? {{16{y[15]}}, y} : {16'd0, y};
        return xe * ye;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Driver: issues one operand pair, scrambles the inputs after acceptance and collects
    // product, digit count and latency (cycles from acceptance to out_valid) from both units.
    task automatic do_mul(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                          input bit rnd_ready);
        bit got0, got1, seen0, seen1;
        int cyc;
        got0 = 0; got1 = 0; seen0 = 0; seen1 = 0;
        res_l0 = -1; res_l1 = -1; res_p0 = 'x; res_p1 = 'x; res_n0 = 'x; res_n1 = 'x;
        @(negedge clk);
        a = ta; b = tb_v; sgn = ts; in_valid = 1'b1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sgn = 1'($urandom);
        cyc = 0;
        while (!(got0 && got1) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (out_valid0 && !got0) begin
                if (!seen0) begin
                    seen0 = 1; res_l0 = cyc; res_p0 = p0; res_n0 = ndig0;
                end else begin
                    chk_cnt++;
                    if (p0 !== res_p0) $display("FAIL hold_p0: got %h expected %h", p0, res_p0);
                    else pass_cnt++;
                end
                if (out_ready) got0 = 1;
            end
            if (out_valid1 && !got1) begin
                if (!seen1) begin
                    seen1 = 1; res_l1 = cyc; res_p1 = p1; res_n1 = ndig1;
                end else begin
                    chk_cnt++;
                    if (p1 !== res_p1) $display("FAIL hold_p1: got %h expected %h", p1, res_p1);
                    else pass_cnt++;
                end
                if (out_ready) got1 = 1;
            end
        end
        if (!(got0 && got1)) begin
            chk_cnt++;
            $display("FAIL mul_timeout: got0=%0d got1=%0d expected both 1", got0, got1);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sgn = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({in_ready0, out_valid0, busy0, ndig0, p0} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'd0})
            $display("FAIL reset_u0: got %b_%b_%b_%h_%h expected 1_0_0_0_00000000",
                     in_ready0, out_valid0, busy0, ndig0, p0);
        else pass_cnt++;
        chk_cnt++;
        if ({in_ready1, out_valid1, busy1, ndig1, p1} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'd0})
            $display("FAIL reset_u1: got %b_%b_%b_%h_%h expected 1_0_0_0_00000000",
                     in_ready1, out_valid1, busy1, ndig1, p1);
        else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_mul(16'h0003, 16'h0005, 1'b1, 1'b0);
        chk_cnt++;
        if (res_p0 !== 32'h0000000F) $display("FAIL basic_p: got %h expected 0000000f", res_p0);
        else pass_cnt++;
        chk_cnt++;
        if (res_n0 !== 4'd8) $display("FAIL basic_ndig: got %0d expected 8", res_n0);
        else pass_cnt++;
        chk_cnt++;
        if (res_l0 != 8) $display("FAIL basic_latency: got %0d expected 8", res_l0);
        else pass_cnt++;
        chk_cnt++;
        if (res_p1 !== 32'h0000000F) $display("FAIL basic_p_et: got %h expected 0000000f", res_p1);
        else pass_cnt++;
    endtask

    task automatic test_signed_extremes();
        logic [15:0] va[3] = '{16'h8000, 16'h7FFF, 16'hFFFF};
        logic [15:0] vb[3] = '{16'h8000, 16'h8000, 16'h0001};
        logic [31:0] vp[3] = '{32'h40000000, 32'hC0008000, 32'hFFFFFFFF};
        for (int k = 0; k < 3; k++) begin
            do_mul(va[k], vb[k], 1'b1, 1'b0);
            chk_cnt++;
            if (res_p0 !== vp[k]) $display("FAIL signed_p[%0d]: got %h expected %h", k, res_p0, vp[k]);
            else pass_cnt++;
            chk_cnt++;
            if (res_p1 !== vp[k]) $display("FAIL signed_p_et[%0d]: got %h expected %h", k, res_p1, vp[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_unsigned();
        do_mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        chk_cnt++;
        if (res_p0 !== 32'hFFFE0001) $display("FAIL unsigned_p: got %h expected fffe0001", res_p0);
        else pass_cnt++;
        chk_cnt++;
        if (res_n0 !== 4'd9) $display("FAIL unsigned_ndig: got %0d expected 9", res_n0);
        else pass_cnt++;
        chk_cnt++;
        if (res_l0 != 9) $display("FAIL unsigned_latency: got %0d expected 9", res_l0);
        else pass_cnt++;
        chk_cnt++;
        if (res_p1 !== 32'hFFFE0001) $display("FAIL unsigned_p_et: got %h expected fffe0001", res_p1);
        else pass_cnt++;
        do_mul(16'h8000, 16'h8000, 1'b0, 1'b0);
        chk_cnt++;
        if (res_p0 !== 32'h40000000) $display("FAIL unsigned_p2: got %h expected 40000000", res_p0);
        else pass_cnt++;
        chk_cnt++;
        if (res_p1 !== 32'h40000000) $display("FAIL unsigned_p2_et: got %h expected 40000000", res_p1);
        else pass_cnt++;
    endtask

    task automatic test_early_term();
        do_mul(16'h1234, 16'h0001, 1'b1, 1'b0);
        chk_cnt++;
        if ({res_p1, res_n1} !== {32'h00001234, 4'd1})
            $display("FAIL et_b1: got p=%h ndig=%0d expected p=00001234 ndig=1", res_p1, res_n1);
        else pass_cnt++;
        do_mul(16'h5A5A, 16'h0000, 1'b1, 1'b0);
        chk_cnt++;
        if ({res_p1, res_n1} !== {32'h00000000, 4'd0})
            $display("FAIL et_b0: got p=%h ndig=%0d expected p=00000000 ndig=0", res_p1, res_n1);
        else pass_cnt++;
        chk_cnt++;
        if ({res_p0, res_n0} !== {32'h00000000, 4'd8})
            $display("FAIL noet_b0: got p=%h ndig=%0d expected p=00000000 ndig=8", res_p0, res_n0);
        else pass_cnt++;
        do_mul(16'h0010, 16'hFFFF, 1'b1, 1'b0);
        chk_cnt++;
        if ({res_p1, res_n1} !== {32'hFFFFFFF0, 4'd1})
            $display("FAIL et_bm1: got p=%h ndig=%0d expected p=fffffff0 ndig=1", res_p1, res_n1);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        a = 16'h1234; b = 16'h0010; sgn = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk_cnt++;
        if (cyc != 8) $display("FAIL bp_latency: got %0d expected 8", cyc);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            chk_cnt++;
            if ({out_valid0, in_ready0, p0} !== {1'b1, 1'b0, 32'h00012340})
                $display("FAIL bp_hold[%0d]: got v=%b r=%b p=%h expected v=1 r=0 p=00012340",
                         k, out_valid0, in_ready0, p0);
            else pass_cnt++;
            in_valid = k[0]; a = 16'hBEEF; b = 16'h0003;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({out_valid0, in_ready0, busy0, out_valid1, busy1} !== 5'b01000)
            $display("FAIL bp_release: got %b%b%b%b%b expected 01000",
                     out_valid0, in_ready0, busy0, out_valid1, busy1);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({busy0, p0} !== {1'b0, 32'h00012340})
            $display("FAIL bp_no_store: got busy=%b p=%h expected busy=0 p=00012340", busy0, p0);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; sgn = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_ready0, out_valid0, busy0, ndig0, p0} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'd0})
            $display("FAIL midrst_u0: got %b_%b_%b_%h_%h expected 1_0_0_0_00000000",
                     in_ready0, out_valid0, busy0, ndig0, p0);
        else pass_cnt++;
        chk_cnt++;
        if ({in_ready1, out_valid1, busy1, ndig1, p1} !== {1'b1, 1'b0, 1'b0, 4'd0, 32'd0})
            $display("FAIL midrst_u1: got %b_%b_%b_%h_%h expected 1_0_0_0_00000000",
                     in_ready1, out_valid1, busy1, ndig1, p1);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(16'h0002, 16'h0003, 1'b1, 1'b0);
        chk_cnt++;
        if ({res_p0, res_p1} !== {32'h00000006, 32'h00000006})
            $display("FAIL midrst_after: got %h %h expected 00000006 00000006", res_p0, res_p1);
        else pass_cnt++;
        chk_cnt++;
        if (res_l0 != 8) $display("FAIL midrst_latency: got %0d expected 8", res_l0);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] ta, tb_v;
        logic        ts;
        logic [31:0] exp_p;
        for (int n = 0; n < 1500; n++) begin
            ta = pick(); tb_v = pick(); ts = 1'($urandom);
            exp_p = model(ta, tb_v, ts);
            do_mul(ta, tb_v, ts, 1'b1);
            chk_cnt++;
            if (res_p0 !== exp_p) $display("FAIL rand_p a=%h b=%h s=%b: got %h expected %h", ta, tb_v, ts, res_p0, exp_p);
            else pass_cnt++;
            chk_cnt++;
            if (res_p1 !== exp_p) $display("FAIL rand_p_et a=%h b=%h s=%b: got %h expected %h", ta, tb_v, ts, res_p1, exp_p);
            else pass_cnt++;
            chk_cnt++;
            if (res_n0 !== (ts ? 4'd8 : 4'd9)) $display("FAIL rand_ndig s=%b: got %0d expected %0d", ts, res_n0, ts ? 8 : 9);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_extremes();
        test_unsigned();
        test_early_term();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
